// File: rtl/line_arb_pkg.sv
// Shared types and defaults for the I/D cacheline arbiter.
package line_arb_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;
  localparam int OFFSET_W   = 5;

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, GAP} state_e;
  typedef enum logic {OP_READ, OP_WRITE} op_e;
  typedef enum logic {REQ_I, REQ_D} req_e;

endpackage

// File: rtl/line_arb_grant.sv
// Combinational winner select between I-cache and D-cache requests.
// RR_EN = 1 favours the requester not granted last; otherwise D_PRIO decides.
module line_arb_grant
  import line_arb_pkg::*;
#(
  parameter bit D_PRIO = 1'b1,
  parameter bit RR_EN  = 1'b0
) (
  input  logic i_req,
  input  logic d_req,
  input  req_e last_grant,
  output logic gnt_valid,
  output req_e gnt
);

  always_comb begin
    gnt_valid = i_req | d_req;
    gnt       = REQ_I;
    if (i_req && d_req) begin
      if (RR_EN) gnt = (last_grant == REQ_I) ? REQ_D : REQ_I;
      else       gnt = D_PRIO ? REQ_D : REQ_I;
    end else if (d_req) begin
      gnt = REQ_D;
    end
  end

endmodule

// File: rtl/line_arbiter.sv
// Shares one cacheline adaptor between the I-cache and the D-cache.
// Define LINE_ARB_RR_EN for round-robin arbitration instead of fixed D_PRIO.
//
// state  | meaning
// IDLE   | evaluate requests, latch winner's op/address/data
// I_BUSY | I-cache transfer in flight, wait for m_resp
// D_BUSY | D-cache transfer in flight, wait for m_resp
// GAP    | one idle cycle so the adaptor returns to idle
module line_arbiter
  import line_arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit D_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                d_req, gnt_valid, busy, grant_now;
  req_e                gnt, last_grant;

  assign d_req     = d_read | d_write;
  assign grant_now = (state_q == IDLE) && gnt_valid;

`ifdef LINE_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  req_e last_q;

  always_ff @(posedge clk) begin
    if (!reset_n)       last_q <= REQ_I;
    else if (grant_now) last_q <= gnt;
  end
  assign last_grant = last_q;
`else
  localparam bit RR_EN = 1'b0;
  assign last_grant = REQ_I;
`endif

  line_arb_grant #(.D_PRIO(D_PRIO), .RR_EN(RR_EN)) u_grant (
    .i_req      (i_read),
    .d_req      (d_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (gnt_valid) state_d = (gnt == REQ_D) ? D_BUSY : I_BUSY;
      I_BUSY, D_BUSY: if (m_resp)    state_d = GAP;
      GAP:            state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Requester inputs are only looked at on the grant cycle; after that the latch owns the bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_now) begin
      if (gnt == REQ_D) begin
        op_q   <= d_write ? OP_WRITE : OP_READ;
        addr_q <= {d_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (d_write) wdata_q <= d_wdata;
      end else begin
        op_q   <= OP_READ;
        addr_q <= {i_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      end
    end
  end

  assign busy    = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign m_read  = reset_n && busy && (op_q == OP_READ);
  assign m_write = reset_n && busy && (op_q == OP_WRITE);
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  // Gated by reset_n so a reset coinciding with m_resp never completes a transfer.
  assign i_resp  = reset_n && (state_q == I_BUSY) && m_resp;
  assign d_resp  = reset_n && (state_q == D_BUSY) && m_resp;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_line_arbiter.sv
// Randomized bench for line_arbiter: the bench plays both caches and the adaptor
// and predicts every grant from the pending-request set and arbitration rule.
module tb_line_arbiter;

  parameter bit TB_D_PRIO = 1'b1;
`ifdef LINE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_read, d_read, d_write, i_resp, d_resp, m_read, m_write, m_resp;
  logic [31:0]  i_addr, d_addr, m_addr;
  logic [255:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;

  line_arbiter #(.LINE_W(256), .ADDR_W(32), .D_PRIO(TB_D_PRIO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // requester model: what each cache currently wants
  bit           i_pend, d_pend, d_wr, d_rd_also, last_d;
  logic [31:0]  i_a, d_a;
  logic [255:0] d_wd;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic drive_inputs();
    i_read  = i_pend;
    i_addr  = i_a;
    d_read  = d_pend && (!d_wr || d_rd_also);
    d_write = d_pend && d_wr;
    d_addr  = d_a;
    d_wdata = d_wd;
  endtask

  task automatic new_requests();
    if (!i_pend && ($urandom() % 2 == 0)) begin
      i_pend = 1'b1;
      i_a    = $urandom();
    end
    if (!d_pend && ($urandom() % 2 == 0)) begin
      d_pend    = 1'b1;
      d_wr      = $urandom() % 2;
      d_rd_also = $urandom() % 2;
      d_a       = $urandom();
      d_wd      = rand_line();
    end
  endtask

  // Starts in an IDLE cycle with at least one request pending; ends in the next IDLE cycle.
  task automatic run_xfer(input int lat, input bit perturb, input bit rand_new, input logic [255:0] rd);
    bit           exp_d, exp_wr;
    logic [31:0]  ea;
    logic [255:0] ewd;
    if (i_pend && d_pend) exp_d = RR ? !last_d : TB_D_PRIO;
    else                  exp_d = d_pend;
    exp_wr = exp_d && d_wr;
    ea     = (exp_d ? d_a : i_a) & 32'hFFFF_FFE0;
    ewd    = d_wd;
    drive_inputs();
    tick();
    check_val("grant_m_read",  m_read,  !exp_wr);
    check_val("grant_m_write", m_write, exp_wr);
    check_val("grant_m_addr",  m_addr,  ea);
    if (exp_wr) check_val("grant_m_wdata", m_wdata, ewd);
    if (perturb) begin
      d_wdata = '0;
      d_addr  = $urandom();
      i_addr  = $urandom();
      if (exp_d) begin d_read = 1'b0; d_write = 1'b0; end
      else       i_read = 1'b0;
      #1;
      check_val("held_m_addr", m_addr, ea);
      if (exp_wr) check_val("held_m_wdata", m_wdata, ewd);
      check_val("held_m_busy", {m_read, m_write}, {!exp_wr, exp_wr});
    end
    for (int k = 0; k < lat; k++) begin
      tick();
      check_val("wait_busy", {m_read, m_write}, {!exp_wr, exp_wr});
      check_val("wait_resp", {i_resp, d_resp}, 2'b00);
    end
    m_resp  = 1'b1;
    m_rdata = rd;
    #1;
    check_val("resp_pair", {i_resp, d_resp}, {!exp_d, exp_d});
    check_val("i_rdata", i_rdata, rd);
    check_val("d_rdata", d_rdata, rd);
    tick();
    m_resp = ($urandom() % 3 == 0);
    if (exp_d) begin
      if (!rand_new || ($urandom() % 4 != 0)) d_pend = 1'b0;
    end else begin
      if (!rand_new || ($urandom() % 4 != 0)) i_pend = 1'b0;
    end
    last_d = exp_d;
    if (rand_new) new_requests();
    drive_inputs();
    #1;
    check_val("gap_idle", {m_read, m_write}, 2'b00);
    check_val("gap_resp", {i_resp, d_resp}, 2'b00);
    tick();
    m_resp = 1'b0;
    #1;
    check_val("idle_quiet", {m_read, m_write, i_resp, d_resp}, 4'b0000);
  endtask

  initial begin
    reset_n = 1'b0; m_resp = 1'b0; m_rdata = '0;
    i_pend = 0; d_pend = 0; d_wr = 0; d_rd_also = 0; last_d = 0;
    i_a = '0; d_a = '0; d_wd = '0;
    drive_inputs();
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    check_val("rst_m_rw",   {m_read, m_write}, 2'b00);
    check_val("rst_resp",   {i_resp, d_resp}, 2'b00);
    check_val("rst_m_addr", m_addr, '0);
    check_val("rst_wdata",  m_wdata, '0);

    // single I read, misaligned address
    i_pend = 1; i_a = 32'h0000_1234;
    run_xfer(4, 1'b0, 1'b0, {32{8'hAA}});
    // D write whose inputs change right after grant
    d_pend = 1; d_wr = 1; d_rd_also = 0; d_a = 32'h8000_0040;
    d_wd = {4{64'h0123_4567_89AB_CDEF}};
    run_xfer(2, 1'b1, 1'b0, rand_line());
    // simultaneous reads: served in arbitration order, one each
    i_pend = 1; i_a = 32'h0000_2000; d_pend = 1; d_wr = 0; d_a = 32'h0000_3000;
    run_xfer(1, 1'b0, 1'b0, rand_line());
    run_xfer(0, 1'b0, 1'b0, rand_line());
    // both held continuously across several transfers
    i_pend = 1; i_a = $urandom(); d_pend = 1; d_wr = 1; d_rd_also = 1; d_a = $urandom(); d_wd = rand_line();
    for (int k = 0; k < 4; k++) begin
      run_xfer(k, 1'b0, 1'b0, rand_line());
      if (!i_pend) i_pend = 1;
      if (!d_pend) d_pend = 1;
    end
    i_pend = 0; d_pend = 0;

    for (int it = 0; it < 300; it++) begin
      if (!i_pend && !d_pend) new_requests();
      if (!i_pend && !d_pend) begin i_pend = 1; i_a = $urandom(); end
      run_xfer($urandom_range(0, 5), $urandom() % 2, 1'b1, rand_line());
    end

    // reset while D_BUSY, with m_resp landing in the reset cycle
    i_pend = 0; d_pend = 1; d_wr = 1; d_rd_also = 0; d_a = $urandom(); d_wd = rand_line();
    drive_inputs();
    tick();
    check_val("pre_rst_write", m_write, 1'b1);
    tick();
    reset_n = 1'b0; m_resp = 1'b1;
    #1;
    check_val("rst_no_d_resp", {i_resp, d_resp}, 2'b00);
    d_pend = 0; i_pend = 1; i_a = $urandom(); last_d = 0;
    drive_inputs();
    tick();
    m_resp = 1'b0;
    #1;
    check_val("post_rst_rw", {m_read, m_write, d_resp}, 3'b000);
    reset_n = 1'b1;
    run_xfer(2, 1'b0, 1'b0, rand_line());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
